load_store_unit: RTL and testbench

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

---
 rtl/lsu_pkg.sv | 46 ++++
 rtl/lsu_lane_extract.sv | 53 +++++
 rtl/load_store_unit.sv | 141 ++++++++++++++
 tb/tb_load_store_unit.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: access size encodings,
// FSM state encoding, lane-count constants and alignment helpers.
package lsu_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_FULL = 2'b11
  } size_e;

  typedef enum logic [1:0] {
    S_IDLE   = 2'b00,
    S_ACCESS = 2'b01,
    S_DONE   = 2'b10,
    S_ERR    = 2'b11
  } state_e;

  localparam int unsigned LANES_BYTE = 1;
  localparam int unsigned LANES_HALF = 2;
  localparam int unsigned LANES_WORD = 4;

  // Width of the memory-wait counter; covers the full TIMEOUT range 1..255.
  localparam int unsigned CNT_W = 8;

  // Number of byte lanes touched by an access of the given size.
  function automatic int unsigned size_lanes(size_e sz, int unsigned full_lanes);
    int unsigned n;
    case (sz)
      SZ_BYTE: n = LANES_BYTE;
      SZ_HALF: n = LANES_HALF;
      SZ_WORD: n = LANES_WORD;
      default: n = full_lanes;
    endcase
    return n;
  endfunction

  // An access is aligned when its lane offset is a multiple of its size.
  function automatic logic lane_aligned(int unsigned off, size_e sz, int unsigned full_lanes);
    int unsigned n;
    n = size_lanes(sz, full_lanes);
    if (sz == SZ_FULL) return (off == 0);
    return ((off & (n - 1)) == 0);
  endfunction

endpackage

// File: rtl/lsu_lane_extract.sv
// Combinational lane steering for a big-endian data bus: builds byte
// enables and positioned store data, and right-justifies/extends load data.
module lsu_lane_extract
  import lsu_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned LB     = 2
) (
  input  logic [1:0]          size,
  input  logic [LB-1:0]       offset,
  input  logic                sign_ext,
  input  logic [DATA_W-1:0]   wdata,
  input  logic [DATA_W-1:0]   mem_rdata,
  output logic [DATA_W/8-1:0] lane_be,
  output logic [DATA_W-1:0]   lane_wdata,
  output logic [DATA_W-1:0]   lane_rdata
);

  localparam int unsigned NB = DATA_W / 8;

  int unsigned       off_i;
  int unsigned       n_lanes;
  int unsigned       sh_lanes;
  logic [DATA_W-1:0] mask;
  logic [DATA_W-1:0] sel;
  logic              sign;

  // Offset 0 is the most significant lane, so the field sits sh_lanes
  // lanes above bit 0 of the bus.
  always_comb begin
    off_i    = 32'(offset);
    n_lanes  = size_lanes(size_e'(size), NB);
    sh_lanes = 0;
    if (off_i + n_lanes <= NB) sh_lanes = NB - off_i - n_lanes;

    mask = '0;
    for (int unsigned i = 0; i < DATA_W; i++) mask[i] = (i < 8 * n_lanes);

    lane_be = '0;
    for (int unsigned k = 0; k < NB; k++)
      lane_be[k] = (k >= sh_lanes) && (k < sh_lanes + n_lanes);

    lane_wdata = (wdata & mask) << (8 * sh_lanes);
    sel        = (mem_rdata >> (8 * sh_lanes)) & mask;

    sign = 1'b0;
    for (int unsigned i = 0; i < DATA_W; i++)
      if (i == 8 * n_lanes - 1) sign = sel[i];

    lane_rdata = (sign_ext && sign) ? (sel | ~mask) : sel;
  end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: accepts one aligned byte/half/word/full access at a time,
// runs a valid/complete handshake with memory with a bounded wait, and
// returns extended load data with a done/err completion pulse.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned TIMEOUT = 15
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic                op_write,
  input  logic [1:0]          size,
  input  logic                sign_ext,
  input  logic [ADDR_W-1:0]   addr,
  input  logic [DATA_W-1:0]   wdata,
  input  logic [DATA_W-1:0]   mem_rdata,
  input  logic                mem_moc,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_be,
  output logic                mem_mov,
  output logic                mem_rw,
  output logic [DATA_W-1:0]   rdata,
  output logic                busy,
  output logic                done,
  output logic                err
);

  localparam int unsigned NB = DATA_W / 8;
  localparam int unsigned LB = $clog2(NB);

  state_e            state, next_state;
  logic [CNT_W-1:0]  cnt;
  logic              r_write;
  logic              r_sext;
  logic [1:0]        r_size;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic              start_ok;
  logic [NB-1:0]     lane_be;
  logic [DATA_W-1:0] lane_wdata;
  logic [DATA_W-1:0] lane_rdata;

  lsu_lane_extract #(
    .DATA_W (DATA_W),
    .LB     (LB)
  ) u_lane (
    .size       (r_size),
    .offset     (r_addr[LB-1:0]),
    .sign_ext   (r_sext),
    .wdata      (r_wdata),
    .mem_rdata  (mem_rdata),
    .lane_be    (lane_be),
    .lane_wdata (lane_wdata),
    .lane_rdata (lane_rdata)
  );

  // Alignment of the incoming request, judged before anything is latched.
  always_comb begin
    start_ok = lane_aligned(32'(addr[LB-1:0]), size_e'(size), NB);
  end

  // State register; reset wins over any start or completion this cycle.
  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= next_state;
  end

  // Next-state and control outputs.
  always_comb begin
    next_state = state;
    busy       = 1'b1;
    done       = 1'b0;
    err        = 1'b0;
    mem_mov    = 1'b0;
    mem_rw     = 1'b0;
    case (state)
      S_IDLE: begin
        busy = 1'b0;
        if (start) next_state = start_ok ? S_ACCESS : S_ERR;
      end
      S_ACCESS: begin
        mem_mov = 1'b1;
        mem_rw  = ~r_write;
        if (mem_moc)                              next_state = S_DONE;
        else if (cnt == CNT_W'(TIMEOUT - 1))      next_state = S_ERR;
      end
      S_DONE: begin
        done       = 1'b1;
        next_state = S_IDLE;
      end
      S_ERR: begin
        done       = 1'b1;
        err        = 1'b1;
        next_state = S_IDLE;
      end
      default: next_state = S_IDLE;
    endcase
  end

  // Bus outputs are driven only while an access is valid, zero otherwise.
  always_comb begin
    mem_addr  = '0;
    mem_wdata = '0;
    mem_be    = '0;
    if (mem_mov) begin
      mem_addr  = {r_addr[ADDR_W-1:LB], {LB{1'b0}}};
      mem_wdata = lane_wdata;
      mem_be    = lane_be;
    end
  end

  // Request capture, wait counter and load result register.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt     <= '0;
      r_write <= 1'b0;
      r_sext  <= 1'b0;
      r_size  <= '0;
      r_addr  <= '0;
      r_wdata <= '0;
      rdata   <= '0;
    end else begin
      if (state == S_IDLE && start) begin
        r_write <= op_write;
        r_sext  <= sign_ext;
        r_size  <= size;
        r_addr  <= addr;
        r_wdata <= wdata;
      end
      // Held at zero outside ACCESS, so it is already clear on entry.
      if (state != S_ACCESS) cnt <= '0;
      else                   cnt <= cnt + 1'b1;
      if (state == S_ACCESS && mem_moc && !r_write) rdata <= lane_rdata;
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b1;

  logic        start = 1'b0, op_write = 1'b0, sign_ext = 1'b0, mem_moc = 1'b0;
  logic [1:0]  size = 2'b00;
  logic [31:0] addr = '0, wdata = '0, mem_rdata = '0;
  logic [31:0] mem_addr, mem_wdata, rdata;
  logic [3:0]  mem_be;
  logic        mem_mov, mem_rw, busy, done, err;

  logic        w_start = 1'b0, w_op_write = 1'b0, w_sign_ext = 1'b0, w_mem_moc = 1'b0;
  logic [1:0]  w_size = 2'b00;
  logic [31:0] w_addr = '0;
  logic [63:0] w_wdata = '0, w_mem_rdata = '0;
  logic [31:0] w_mem_addr;
  logic [63:0] w_mem_wdata, w_rdata;
  logic [7:0]  w_mem_be;
  logic        w_mem_mov, w_mem_rw, w_busy, w_done, w_err;

  int checks = 0;
  int errors = 0;
  int n;

  always #5 clk = ~clk;

  load_store_unit #(.DATA_W(32), .ADDR_W(32), .TIMEOUT(15)) dut (
    .clk(clk), .reset(reset), .start(start), .op_write(op_write), .size(size),
    .sign_ext(sign_ext), .addr(addr), .wdata(wdata), .mem_rdata(mem_rdata),
    .mem_moc(mem_moc), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_be(mem_be),
    .mem_mov(mem_mov), .mem_rw(mem_rw), .rdata(rdata), .busy(busy), .done(done), .err(err)
  );

  load_store_unit #(.DATA_W(64), .ADDR_W(32), .TIMEOUT(15)) dut64 (
    .clk(clk), .reset(reset), .start(w_start), .op_write(w_op_write), .size(w_size),
    .sign_ext(w_sign_ext), .addr(w_addr), .wdata(w_wdata), .mem_rdata(w_mem_rdata),
    .mem_moc(w_mem_moc), .mem_addr(w_mem_addr), .mem_wdata(w_mem_wdata), .mem_be(w_mem_be),
    .mem_mov(w_mem_mov), .mem_rw(w_mem_rw), .rdata(w_rdata), .busy(w_busy), .done(w_done),
    .err(w_err)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic req(input logic wr, input logic [1:0] sz, input logic sx,
                     input logic [31:0] a, input logic [31:0] wd);
    op_write = wr; size = sz; sign_ext = sx; addr = a; wdata = wd; start = 1'b1;
  endtask

  initial begin
    // Reset state
    repeat (3) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    check("rst_mov", mem_mov, 0);
    check("rst_be", mem_be, 0);
    check("rst_rdata", rdata, 0);
    reset = 1'b0;

    // Signed byte load at lane offset 3, complete on first ACCESS cycle
    req(1'b0, 2'b00, 1'b1, 32'h0000_1003, 32'h0);
    mem_rdata = 32'h1234_56F0; mem_moc = 1'b1;
    @(negedge clk); start = 1'b0;
    check("lb_mov", mem_mov, 1);
    check("lb_rw", mem_rw, 1);
    check("lb_be", mem_be, 4'b0001);
    check("lb_addr", mem_addr, 32'h0000_1000);
    check("lb_busy", busy, 1);
    check("lb_done_early", done, 0);
    @(negedge clk);
    check("lb_done", done, 1);
    check("lb_err", err, 0);
    check("lb_rdata", rdata, 32'hFFFF_FFF0);
    check("lb_mov_off", mem_mov, 0);
    // start during DONE is ignored
    req(1'b0, 2'b10, 1'b0, 32'h0000_1000, 32'h0);
    @(negedge clk); start = 1'b0;
    check("b2b_busy", busy, 0);
    check("b2b_mov", mem_mov, 0);
    @(negedge clk);
    check("b2b_still_idle", busy, 0);

    // Signed halfword load at offset 0
    req(1'b0, 2'b01, 1'b1, 32'h0000_1000, 32'h0);
    mem_rdata = 32'h8765_4321;
    @(negedge clk); start = 1'b0;
    check("lh_be", mem_be, 4'b1100);
    @(negedge clk);
    check("lh_rdata", rdata, 32'hFFFF_8765);
    @(negedge clk);

    // Zero-extended byte load at offset 1
    req(1'b0, 2'b00, 1'b0, 32'h0000_1001, 32'h0);
    mem_rdata = 32'h12B4_5678;
    @(negedge clk); start = 1'b0;
    check("lbu_be", mem_be, 4'b0100);
    @(negedge clk);
    check("lbu_rdata", rdata, 32'h0000_00B4);
    @(negedge clk);

    // Halfword store at offset 2, memory waits one cycle
    mem_moc = 1'b0;
    req(1'b1, 2'b01, 1'b0, 32'h0000_2002, 32'h0000_ABCD);
    @(negedge clk); start = 1'b0;
    check("sh_addr", mem_addr, 32'h0000_2000);
    check("sh_be", mem_be, 4'b0011);
    check("sh_wdata", mem_wdata, 32'h0000_ABCD);
    check("sh_rw", mem_rw, 0);
    check("sh_mov", mem_mov, 1);
    mem_moc = 1'b1;
    @(negedge clk);
    check("sh_done", done, 1);
    check("sh_rdata_kept", rdata, 32'h0000_00B4);
    @(negedge clk);

    // Byte store at offset 0 goes to the top lane
    req(1'b1, 2'b00, 1'b0, 32'h0000_2000, 32'h0000_005A);
    @(negedge clk); start = 1'b0;
    check("sb_be", mem_be, 4'b1000);
    check("sb_wdata", mem_wdata, 32'h5A00_0000);
    @(negedge clk);
    @(negedge clk);

    // Misaligned word load
    req(1'b0, 2'b10, 1'b0, 32'h0000_3001, 32'h0);
    @(negedge clk); start = 1'b0;
    check("mis_done", done, 1);
    check("mis_err", err, 1);
    check("mis_mov", mem_mov, 0);
    check("mis_busy", busy, 1);
    @(negedge clk);
    check("mis_idle", busy, 0);
    check("mis_done_off", done, 0);
    // Misaligned halfword load
    req(1'b0, 2'b01, 1'b0, 32'h0000_3003, 32'h0);
    @(negedge clk); start = 1'b0;
    check("mish_err", err, 1);
    check("mish_mov", mem_mov, 0);
    @(negedge clk);

    // Timeout: memory never completes
    mem_moc = 1'b0;
    req(1'b0, 2'b10, 1'b0, 32'h0000_3000, 32'h0);
    @(negedge clk); start = 1'b0;
    n = 0;
    while (mem_mov === 1'b1 && n < 40) begin
      n++;
      @(negedge clk);
    end
    check("to_mov_cycles", n, 15);
    check("to_done", done, 1);
    check("to_err", err, 1);
    @(negedge clk);

    // Completion on the last permitted wait cycle is a normal completion
    mem_rdata = 32'hCAFE_F00D;
    req(1'b0, 2'b10, 1'b0, 32'h0000_3004, 32'h0);
    @(negedge clk); start = 1'b0;
    repeat (14) @(negedge clk);
    check("edge_mov", mem_mov, 1);
    mem_moc = 1'b1;
    @(negedge clk);
    check("edge_done", done, 1);
    check("edge_err", err, 0);
    check("edge_rdata", rdata, 32'hCAFE_F00D);
    mem_moc = 1'b0;
    @(negedge clk);

    // Reset on the third ACCESS cycle aborts without done
    req(1'b0, 2'b10, 1'b0, 32'h0000_3000, 32'h0);
    @(negedge clk); start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("pre_rst_mov", mem_mov, 1);
    reset = 1'b1;
    @(negedge clk);
    check("abort_mov", mem_mov, 0);
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_rdata", rdata, 0);
    // Reset beats start and mem_moc in the same cycle
    req(1'b0, 2'b10, 1'b0, 32'h0000_3000, 32'h0);
    mem_moc = 1'b1;
    @(negedge clk);
    check("rst_prio_busy", busy, 0);
    check("rst_prio_mov", mem_mov, 0);
    reset = 1'b0; start = 1'b0;
    @(negedge clk);
    check("rst_prio_idle", busy, 0);

    // 64-bit bus: full-width load and signed word load
    w_op_write = 1'b0; w_size = 2'b11; w_sign_ext = 1'b1; w_addr = 32'h0000_0040;
    w_mem_rdata = 64'h0123_4567_89AB_CDEF; w_mem_moc = 1'b1; w_start = 1'b1;
    @(negedge clk); w_start = 1'b0;
    check("w_full_be", w_mem_be, 8'hFF);
    check("w_full_mov", w_mem_mov, 1);
    check("w_full_addr", w_mem_addr, 32'h0000_0040);
    @(negedge clk);
    check("w_full_done", w_done, 1);
    check("w_full_rdata", w_rdata, 64'h0123_4567_89AB_CDEF);
    @(negedge clk);
    w_size = 2'b10; w_addr = 32'h0000_0044; w_mem_rdata = 64'h0000_0000_F000_0001;
    w_start = 1'b1;
    @(negedge clk); w_start = 1'b0;
    check("w_word_be", w_mem_be, 8'h0F);
    check("w_word_addr", w_mem_addr, 32'h0000_0040);
    @(negedge clk);
    check("w_word_rdata", w_rdata, 64'hFFFF_FFFF_F000_0001);
    @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
